cordic_capture: RTL

Downstream sample-capture stage for the cordic NCO/mixer. It takes the 20-bit complex re/im stream and, once armed, waits for a trigger. It then stores a decimated block of DEPTH complex samples into on-chip RAM and exposes the block through a simple read port. It gives the host/VNA logic a hardware snapshot of the cordic output.

---
 rtl/cordic_capture.sv | 125 ++++++++++++
 1 files changed

// File: rtl/cordic_capture.sv
// Capture stage for the cordic re/im stream: arm, trigger, store a decimated
// block of DEPTH complex samples, and read it back through a synchronous port.
`default_nettype none

module cordic_capture #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 20
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  input  logic          in_valid,
  input  logic          arm,
  input  logic          trig_mode,
  input  logic [7:0]    decim,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   count,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_re,
  output logic [DW-1:0] rd_im,
  output logic          rd_valid
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  state_t          state, state_nxt;
  logic [AW:0]     count_nxt;
  logic [7:0]      decim_r;
  logic [7:0]      dcnt, dcnt_nxt, dcnt_inc;
  logic            prev_neg;
  logic            trig_fire;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [2*DW-1:0] mem [DEPTH];

  // A sample of exactly zero counts as non-negative for the rising crossing.
  assign trig_fire = !trig_mode || (prev_neg && !in_re[DW-1]);
  assign dcnt_inc  = (dcnt == decim_r) ? 8'd0 : dcnt + 8'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    dcnt_nxt  = dcnt;
    wr_en     = 1'b0;
    wr_addr   = count[AW-1:0];
    if (arm) begin
      state_nxt = S_ARMED;
      count_nxt = '0;
    end else if (in_valid) begin
      case (state)
        S_ARMED: begin
          if (trig_fire) begin
            wr_en     = 1'b1;
            wr_addr   = '0;
            count_nxt = (AW + 1)'(1);
            dcnt_nxt  = 8'd0;
            state_nxt = (count_nxt == FULL) ? S_DONE : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          dcnt_nxt = dcnt_inc;
          if (dcnt_inc == 8'd0) begin
            wr_en     = 1'b1;
            count_nxt = count + (AW + 1)'(1);
            if (count_nxt == FULL) state_nxt = S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      dcnt     <= 8'd0;
      decim_r  <= 8'd0;
      prev_neg <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      count <= count_nxt;
      dcnt  <= dcnt_nxt;
      busy  <= (state_nxt == S_ARMED) || (state_nxt == S_CAPTURE);
      done  <= (state_nxt == S_DONE);
      if (arm)      decim_r  <= decim;
      if (in_valid) prev_neg <= in_re[DW-1];
    end
  end

  // Storage has no reset so it maps onto block RAM; re sits in the upper half.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= {in_re, in_im};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_re    <= '0;
      rd_im    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) {rd_re, rd_im} <= mem[rd_addr];
    end
  end

endmodule

`default_nettype wire
